// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction-fetch unit: FSM encoding, AXI read
// response codes and the two build reset vectors.
package ifu_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  localparam logic [1:0] RESP_OK     = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] RESET_VEC_STANDALONE = 32'h8000_0000;
  localparam logic [31:0] RESET_VEC_SOC        = 32'h3000_0000;

  function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
    return pc_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Bundle of the PC handshake, instruction-memory read channel and decode
// handshake seen by the fetch unit. "master" is the fetch unit's view.
interface ifu_fetch_if #(parameter int DATA_WIDTH = 32);

  logic [DATA_WIDTH-1:0] pc;
  logic                  pc_ready;
  logic [DATA_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] inst;
  logic [DATA_WIDTH-1:0] inst_pc;
  logic                  inst_valid;
  logic                  inst_ready;
  logic                  fetch_err;
  logic                  overrun;
  logic                  busy;

  modport master (
    input  pc, pc_ready, arready, rdata, rresp, rvalid, inst_ready,
    output araddr, arvalid, rready, inst, inst_pc, inst_valid, fetch_err,
           overrun, busy
  );

  modport slave (
    output pc, pc_ready, arready, rdata, rresp, rvalid, inst_ready,
    input  araddr, arvalid, rready, inst, inst_pc, inst_valid, fetch_err,
           overrun, busy
  );

endinterface

// File: rtl/ifu_pending_buf.sv
// One-entry skid buffer for PCs announced while the fetch FSM is occupied,
// with a sticky flag for pulses that arrive when the entry is already taken.
module ifu_pending_buf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic                  pc_ready_i,
  input  logic                  fsm_idle_i,
  input  logic                  drain_i,
  output logic [DATA_WIDTH-1:0] pending_pc_o,
  output logic                  pending_v_o,
  output logic                  overrun_o
);

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  v_q, v_d;
  logic                  ovr_q, ovr_d;
  logic                  store;

  // An idle FSM with an empty buffer takes the PC directly; a drain in the
  // same cycle frees the slot, so a simultaneous pulse refills it.
  always_comb begin
    store = pc_ready_i && (!fsm_idle_i || v_q);
    pc_d  = pc_q;
    v_d   = v_q;
    ovr_d = ovr_q;
    if (drain_i) begin
      v_d = 1'b0;
    end
    if (store) begin
      if (v_q && !drain_i) begin
        ovr_d = 1'b1;
      end else begin
        pc_d = pc_i;
        v_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= '0;
      v_q   <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      v_q   <= v_d;
      ovr_q <= ovr_d;
    end
  end

  assign pending_pc_o = pc_q;
  assign pending_v_o  = v_q;
  assign overrun_o    = ovr_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch unit: one memory read per announced PC, result handed to
// decode over valid/ready, with a one-entry pending PC buffer.
module ifu_fetch #(
  parameter int         DATA_WIDTH = 32,
  parameter logic [1:0] RESP_OK    = 2'b00
) (
  input logic         clk,
  input logic         rst_n,
  ifu_fetch_if.master bus
);
  import ifu_fetch_pkg::fetch_state_e;
  import ifu_fetch_pkg::IDLE;
  import ifu_fetch_pkg::ADDR;
  import ifu_fetch_pkg::DATA;
  import ifu_fetch_pkg::HOLD;
  import ifu_fetch_pkg::pc_misaligned;

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic [DATA_WIDTH-1:0] inst_pc_q, inst_pc_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] pending_pc;
  logic                  pending_v;
  logic                  overrun;
  logic                  drain;
  logic                  launch;
  logic [DATA_WIDTH-1:0] launch_pc;

  ifu_pending_buf #(.DATA_WIDTH(DATA_WIDTH)) u_pending (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_i         (bus.pc),
    .pc_ready_i   (bus.pc_ready),
    .fsm_idle_i   (state_q == IDLE),
    .drain_i      (drain),
    .pending_pc_o (pending_pc),
    .pending_v_o  (pending_v),
    .overrun_o    (overrun)
  );

  // A pending PC always has priority over a fresh pulse so program order is
  // kept; misaligned PCs skip the bus and report straight to decode.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    err_d     = err_q;
    drain     = 1'b0;
    launch    = 1'b0;
    launch_pc = bus.pc;
    case (state_q)
      IDLE: begin
        if (pending_v) begin
          launch    = 1'b1;
          launch_pc = pending_pc;
          drain     = 1'b1;
        end else if (bus.pc_ready) begin
          launch = 1'b1;
        end
      end
      ADDR: begin
        if (bus.arready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bus.rvalid) begin
          inst_d    = bus.rdata;
          inst_pc_d = addr_q;
          err_d     = (bus.rresp != RESP_OK);
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (bus.inst_ready) begin
          if (pending_v) begin
            launch    = 1'b1;
            launch_pc = pending_pc;
            drain     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (launch) begin
      if (pc_misaligned(launch_pc[1:0])) begin
        state_d   = HOLD;
        inst_d    = '0;
        inst_pc_d = launch_pc;
        err_d     = 1'b1;
      end else begin
        state_d = ADDR;
        addr_d  = launch_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      err_q     <= err_d;
    end
  end

  assign bus.araddr     = addr_q;
  assign bus.arvalid    = (state_q == ADDR);
  assign bus.rready     = (state_q == DATA);
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_valid = (state_q == HOLD);
  assign bus.fetch_err  = err_q;
  assign bus.overrun    = overrun;
  assign bus.busy       = (state_q != IDLE) || pending_v;

endmodule
